// File: rtl/ezusb_slave_fifo_model.sv
// Behavioural-but-synthesizable stand-in for the FX2 side of the synchronous slave-FIFO bus.
// EP2 carries host->FPGA bytes, EP6 carries FPGA->host bytes released to the host in committed packets.
module ezusb_slave_fifo_model #(
   parameter int         DEPTH    = 512,
   parameter int         AW       = 9,
   parameter int         PKT_SIZE = 512,
   parameter int         PKTQ     = 4,
   parameter logic [1:0] OUT_ADR  = 2'b00,
   parameter logic [1:0] IN_ADR   = 2'b10
) (
   input  logic       ifclk,
   input  logic       rst,
   input  logic       sloe,
   input  logic       slrd,
   input  logic       slwr,
   input  logic [1:0] fifoadr,
   input  logic       pktend,
   inout  wire  [7:0] fd,
   output logic       flaga,
   output logic       flagb,
   output logic       flagc,
   output logic       flagd,
   input  logic [7:0] host_out_data,
   input  logic       host_out_valid,
   output logic       host_out_ready,
   output logic [7:0] host_in_data,
   output logic       host_in_valid,
   input  logic       host_in_ready,
   output logic       host_in_last,
   output logic       err_underrun,
   output logic       err_overflow,
   output logic       err_contention
);

   localparam int          QW        = (PKTQ > 1) ? $clog2(PKTQ) : 1;
   localparam logic [AW:0] LP_DEPTH  = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_DEPTHM = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] LP_PKT    = (AW+1)'(PKT_SIZE);
   localparam logic [QW:0] LP_PKTQ   = (QW+1)'(PKTQ);

   logic [7:0]    r_ep2_mem [DEPTH];
   logic [7:0]    r_ep6_mem [DEPTH];
   logic [AW:0]   r_pq_mem  [PKTQ];

   logic [AW-1:0] r_ep2_rd, r_ep2_wr, r_ep6_rd, r_ep6_wr;
   logic [AW:0]   r_ep2_cnt, r_ep6_cnt, r_unc, r_in_pos;
   logic [QW-1:0] r_pq_rd, r_pq_wr;
   logic [QW:0]   r_pq_cnt;

   logic          r_flaga, r_flagb, r_flagc, r_flagd;
   logic          r_out_ready, r_in_valid;
   logic          r_err_underrun, r_err_overflow, r_err_contention;

   logic          w_sel_out, w_sel_in;
   logic          w_ep2_push, w_ep2_pop, w_ep2_underrun;
   logic          w_ep6_full, w_ep6_wr, w_ep6_overflow;
   logic          w_commit, w_xfer, w_pq_pop, w_in_last, w_fd_oe;
   logic [7:0]    w_ep2_head;
   logic [AW:0]   w_unc_sum, w_head_len;
   logic [AW:0]   w_ep2_cnt_nx, w_ep6_cnt_nx, w_unc_nx;
   logic [QW:0]   w_pq_cnt_nx;

   assign w_sel_out  = (fifoadr == OUT_ADR);
   assign w_sel_in   = (fifoadr == IN_ADR);
   assign w_ep2_head = r_ep2_mem[r_ep2_rd];

   assign w_ep2_push     = host_out_valid && r_out_ready;
   assign w_ep2_pop      = !slrd && w_sel_out && (r_ep2_cnt != '0);
   assign w_ep2_underrun = !slrd && w_sel_out && (r_ep2_cnt == '0);

   // The bus is only ours while the FPGA is not itself driving a write.
   assign w_fd_oe = !sloe && w_sel_out && slwr;
   assign fd      = w_fd_oe ? w_ep2_head : 8'bzzzz_zzzz;

   assign w_ep6_full     = (r_ep6_cnt == LP_DEPTH) || (r_pq_cnt == LP_PKTQ);
   assign w_ep6_wr       = !slwr && w_sel_in && !w_ep6_full;
   assign w_ep6_overflow = !slwr && w_sel_in && w_ep6_full;

   // A byte written in the commit cycle belongs to the packet being closed.
   assign w_unc_sum = r_unc + (AW+1)'(w_ep6_wr);
   assign w_commit  = (w_unc_sum != '0) && (r_pq_cnt != LP_PKTQ) &&
                      ((!pktend && w_sel_in) || (w_unc_sum == LP_PKT));

   assign w_head_len = r_pq_mem[r_pq_rd];
   assign w_in_last  = r_in_valid && (r_in_pos == (w_head_len - (AW+1)'(1)));
   assign w_xfer     = r_in_valid && host_in_ready;
   assign w_pq_pop   = w_xfer && w_in_last;

   // Next-state occupancy, shared by the counters and the registered flags.
   always_comb begin
      w_ep2_cnt_nx = r_ep2_cnt;
      w_ep6_cnt_nx = r_ep6_cnt;
      w_pq_cnt_nx  = r_pq_cnt;
      w_unc_nx     = r_unc;
      case ({w_ep2_push, w_ep2_pop})
         2'b10:   w_ep2_cnt_nx = r_ep2_cnt + (AW+1)'(1);
         2'b01:   w_ep2_cnt_nx = r_ep2_cnt - (AW+1)'(1);
         default: w_ep2_cnt_nx = r_ep2_cnt;
      endcase
      case ({w_ep6_wr, w_xfer})
         2'b10:   w_ep6_cnt_nx = r_ep6_cnt + (AW+1)'(1);
         2'b01:   w_ep6_cnt_nx = r_ep6_cnt - (AW+1)'(1);
         default: w_ep6_cnt_nx = r_ep6_cnt;
      endcase
      case ({w_commit, w_pq_pop})
         2'b10:   w_pq_cnt_nx = r_pq_cnt + (QW+1)'(1);
         2'b01:   w_pq_cnt_nx = r_pq_cnt - (QW+1)'(1);
         default: w_pq_cnt_nx = r_pq_cnt;
      endcase
      if (w_commit) begin
         w_unc_nx = '0;
      end else begin
         w_unc_nx = w_unc_sum;
      end
   end

   // Storage arrays carry no reset; pointers and counts define what is valid.
   always_ff @(posedge ifclk) begin
      if (w_ep2_push) begin
         r_ep2_mem[r_ep2_wr] <= host_out_data;
      end
      if (w_ep6_wr) begin
         r_ep6_mem[r_ep6_wr] <= fd;
      end
      if (w_commit) begin
         r_pq_mem[r_pq_wr] <= w_unc_sum;
      end
   end

   // Pointers, counters, flags and sticky error bits.
   always_ff @(posedge ifclk) begin
      if (rst) begin
         r_ep2_rd         <= '0;
         r_ep2_wr         <= '0;
         r_ep6_rd         <= '0;
         r_ep6_wr         <= '0;
         r_ep2_cnt        <= '0;
         r_ep6_cnt        <= '0;
         r_unc            <= '0;
         r_in_pos         <= '0;
         r_pq_rd          <= '0;
         r_pq_wr          <= '0;
         r_pq_cnt         <= '0;
         r_flaga          <= 1'b0;
         r_flagb          <= 1'b1;
         r_flagc          <= 1'b0;
         r_flagd          <= 1'b1;
         r_out_ready      <= 1'b1;
         r_in_valid       <= 1'b0;
         r_err_underrun   <= 1'b0;
         r_err_overflow   <= 1'b0;
         r_err_contention <= 1'b0;
      end else begin
         if (w_ep2_push) r_ep2_wr <= r_ep2_wr + AW'(1);
         if (w_ep2_pop)  r_ep2_rd <= r_ep2_rd + AW'(1);
         if (w_ep6_wr)   r_ep6_wr <= r_ep6_wr + AW'(1);
         if (w_xfer)     r_ep6_rd <= r_ep6_rd + AW'(1);
         if (w_commit)   r_pq_wr  <= r_pq_wr + QW'(1);
         if (w_pq_pop)   r_pq_rd  <= r_pq_rd + QW'(1);

         if (w_pq_pop) begin
            r_in_pos <= '0;
         end else if (w_xfer) begin
            r_in_pos <= r_in_pos + (AW+1)'(1);
         end else begin
            r_in_pos <= r_in_pos;
         end

         r_ep2_cnt <= w_ep2_cnt_nx;
         r_ep6_cnt <= w_ep6_cnt_nx;
         r_pq_cnt  <= w_pq_cnt_nx;
         r_unc     <= w_unc_nx;

         r_flaga     <= (w_ep2_cnt_nx != '0);
         r_flagc     <= (w_ep2_cnt_nx > (AW+1)'(1));
         r_flagb     <= !((w_ep6_cnt_nx == LP_DEPTH) || (w_pq_cnt_nx == LP_PKTQ));
         r_flagd     <= (w_ep6_cnt_nx < LP_DEPTHM);
         r_out_ready <= (w_ep2_cnt_nx != LP_DEPTH);
         r_in_valid  <= (w_pq_cnt_nx != '0);

         r_err_underrun   <= r_err_underrun   | w_ep2_underrun;
         r_err_overflow   <= r_err_overflow   | w_ep6_overflow;
         r_err_contention <= r_err_contention | (!sloe && !slwr);
      end
   end

   assign flaga          = r_flaga;
   assign flagb          = r_flagb;
   assign flagc          = r_flagc;
   assign flagd          = r_flagd;
   assign host_out_ready = r_out_ready;
   assign host_in_valid  = r_in_valid;
   assign host_in_data   = r_ep6_mem[r_ep6_rd];
   assign host_in_last   = w_in_last;
   assign err_underrun   = r_err_underrun;
   assign err_overflow   = r_err_overflow;
   assign err_contention = r_err_contention;

endmodule

// File: doc/ezusb_slave_fifo_model.md
Name: ezusb_slave_fifo_model

Overview:
- Synthesizable model of the EZ-USB FX2 side of the synchronous slave-FIFO bus: the responder that the FPGA-side interface drives.
- Holds two endpoint FIFOs:
  - EP2 (OUT): host writes it; the FPGA reads it over fd.
  - EP6 (IN): the FPGA writes it over fd; the host drains it in committed packets.
- Used in system benches and loopback builds.
- Presents flaga..flagd and fd exactly as the FX2 does, with FX2 default active-low strobes and flags.

Parameters:
- DEPTH, 512, bytes per endpoint FIFO; power of 2.
- AW, 9, log2(DEPTH).
- PKT_SIZE, 512, EP6 auto-commit length in bytes.
- PKTQ, 4, max committed-but-undrained EP6 packets.
- OUT_ADR, 2'b00, fifoadr value selecting EP2.
- IN_ADR, 2'b10, fifoadr value selecting EP6.

Ports:
- ifclk  in  1  interface clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- sloe  in  1  active-low output enable for fd.
- slrd  in  1  active-low read strobe.
- slwr  in  1  active-low write strobe.
- fifoadr  in  2  endpoint select.
- pktend  in  1  active-low packet commit for EP6.
- fd  inout  8  slave-FIFO data bus.
- flaga  out  1  EP2 empty, active-low.
- flagb  out  1  EP6 full, active-low.
- flagc  out  1  EP2 almost-empty (count<=1), active-low.
- flagd  out  1  EP6 almost-full (count>=DEPTH-1), active-low.
- host_out_data  in  8  host byte into EP2.
- host_out_valid  in  1  host byte valid.
- host_out_ready  out  1  EP2 not full.
- host_in_data  out  8  EP6 head byte.
- host_in_valid  out  1  committed EP6 byte available.
- host_in_ready  in  1  host accepts byte.
- host_in_last  out  1  current byte ends a committed packet.
- err_underrun  out  1  sticky; slrd on empty EP2.
- err_overflow  out  1  sticky; slwr on full EP6.
- err_contention  out  1  sticky; sloe and slwr both low.

Behaviour:
Reset (rst=1 at edge):
- Pointers, counts and packet queue are cleared.
- flaga=0, flagb=1, flagc=0, flagd=1.
- fd=Z, host_in_valid=0, host_in_last=0, host_out_ready=1, all err_*=0.
- Reset mid-transfer discards all data, including uncommitted EP6 bytes.

fd drive:
- fd is driven with the EP2 head byte (first-word fall-through) only when sloe=0, fifoadr=OUT_ADR and slwr=1.
- Otherwise fd=Z.
- If sloe=0 and slwr=0 in the same cycle, fd=Z and err_contention is set.

EP2 read:
- Pop occurs at an edge where slrd=0, fifoadr=OUT_ADR and EP2 is not empty.
- The new head byte is on fd one cycle after the popping edge.
- slrd=0 on empty EP2: no pop, err_underrun set.

EP2 host write:
- Push occurs when host_out_valid and host_out_ready.
- A simultaneous push and pop leaves the count unchanged.
- An empty-FIFO push with a simultaneous slrd attempt: no pop, err_underrun set; the byte is visible the next cycle.

EP6 write:
- fd is sampled at an edge where slwr=0, fifoadr=IN_ADR and EP6 is not full.
- slwr=0 while full: byte dropped, err_overflow set.
- "Full" means count==DEPTH, or the packet queue is full with PKTQ entries.

Commit:
- pktend=0 with fifoadr=IN_ADR commits all uncommitted bytes as one packet.
- If slwr=0 in the same cycle, that byte is included in the packet.
- The packet reaches 512 bytes automatically at the PKT_SIZE-th uncommitted byte.
- pktend with zero uncommitted bytes is ignored (no ZLP).
- A committed packet pushes its length into the packet queue.

Host drain:
- host_in_valid=1 while a packet is committed.
- Transfer occurs when valid and ready.
- host_in_last=1 on the final byte of each packet; that transfer pops the queue.
- Uncommitted bytes are never visible to the host.

Flags:
- All four flags are registered from next-state counts, so they update one cycle after the causing edge.
- Other fifoadr values (01, 11): strobes are ignored; fd stays Z.

Test Plan:
1. Reset, then host pushes 0x11,0x22,0x33; FPGA holds sloe=0, slrd=0 for 3 cycles → fd shows 0x11,0x22,0x33; flaga rises 1 cycle after the first push; flaga=0 after the last pop; err_underrun stays 0.
2. FPGA writes 5 bytes 0xA0..0xA4, then pktend=0 with slwr=1 → host_in_valid=1; host receives 5 bytes with host_in_last on 0xA4 only; before pktend, host_in_valid=0.
3. Write exactly 512 bytes with no pktend → auto-commit; flagd low at count 511; flagb low at 512; a 513th slwr sets err_overflow and the byte is dropped.
4. slrd=0 on empty EP2 → err_underrun=1, stays set until rst; sloe=0 with slwr=0 → fd=Z, err_contention=1.
5. pktend=0 coincident with slwr=0 writing 0x5A after 2 prior bytes → packet length 3, last byte 0x5A; pktend with nothing pending → no packet.
6. Assert rst mid-packet (3 uncommitted EP6 bytes, 2 EP2 bytes) → all flags and outputs return to reset values; host_in_valid=0.
